// File: rtl/adpll_cfg_pkg.sv
// Shared constants and FSM encoding for the ADPLL configuration controller.
package adpll_cfg_pkg;

   localparam logic [2:0] ADDR_NDIV   = 3'd0;
   localparam logic [2:0] ADDR_ALPHA  = 3'd1;
   localparam logic [2:0] ADDR_BETA   = 3'd2;
   localparam logic [2:0] ADDR_OFFSET = 3'd3;
   localparam logic [2:0] ADDR_THRESH = 3'd4;
   localparam logic [2:0] ADDR_KDCO   = 3'd5;
   localparam logic [2:0] ADDR_COMMIT = 3'd6;
   localparam logic [2:0] ADDR_CLEAR  = 3'd7;

   localparam int         NUM_REGS    = 6;
   localparam logic [3:0] NDIV_MIN    = 4'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      APPLY  = 2'd2,
      SETTLE = 2'd3
   } state_t;

endpackage

// File: rtl/adpll_cfg_ctrl_if.sv
// Command port of the ADPLL configuration controller (valid/ready write channel).
interface adpll_cfg_ctrl_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_addr;
   logic [4:0] cmd_data;

   modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);

endinterface

// File: rtl/adpll_cfg_regbank.sv
// Shadow/active register pairs: shadows take writes, actives copy all shadows on apply.
module adpll_cfg_regbank
   import adpll_cfg_pkg::*;
(
   input  logic                clk,
   input  logic                clr,
   input  logic [NUM_REGS-1:0] wr_en,
   input  logic [4:0]          wr_data,
   input  logic                clear,
   input  logic                apply,
   output logic [3:0]          shd_ndiv,
   output logic [3:0]          ndiv,
   output logic [4:0]          alpha,
   output logic [4:0]          beta,
   output logic [4:0]          dco_offset,
   output logic [4:0]          dco_thresh,
   output logic [4:0]          kdco
);

   // ndiv is 4 bits wide and kept apart; the five 5-bit registers share an array (index = addr-1)
   logic [3:0] shd_ndiv_q, shd_ndiv_d;
   logic [3:0] act_ndiv_q, act_ndiv_d;
   logic [4:0] shd_q [NUM_REGS-1];
   logic [4:0] shd_d [NUM_REGS-1];
   logic [4:0] act_q [NUM_REGS-1];
   logic [4:0] act_d [NUM_REGS-1];

   always_comb begin
      shd_ndiv_d = shd_ndiv_q;
      act_ndiv_d = act_ndiv_q;
      shd_d      = shd_q;
      act_d      = act_q;
      if (clear)
         shd_ndiv_d = '0;
      else if (wr_en[0])
         shd_ndiv_d = wr_data[3:0];
      if (apply)
         act_ndiv_d = shd_ndiv_q;
      for (int i = 0; i < NUM_REGS-1; i++) begin
         if (clear)
            shd_d[i] = '0;
         else if (wr_en[i+1])
            shd_d[i] = wr_data;
         if (apply)
            act_d[i] = shd_q[i];
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         shd_ndiv_q <= '0;
         act_ndiv_q <= '0;
         shd_q      <= '{default: '0};
         act_q      <= '{default: '0};
      end else begin
         shd_ndiv_q <= shd_ndiv_d;
         act_ndiv_q <= act_ndiv_d;
         shd_q      <= shd_d;
         act_q      <= act_d;
      end
   end

   assign shd_ndiv   = shd_ndiv_q;
   assign ndiv       = act_ndiv_q;
   assign alpha      = act_q[0];
   assign beta       = act_q[1];
   assign dco_offset = act_q[2];
   assign dco_thresh = act_q[3];
   assign kdco       = act_q[4];

endmodule

// File: rtl/adpll_cfg_ctrl.sv
// ADPLL configuration controller: shadow writes, then commit as hold-reset / apply / settle.
//
//   state  | meaning
//   IDLE   | accepting commands, core running (or in reset until first apply)
//   HOLD   | core held in reset for HOLD_CYC cycles
//   APPLY  | one cycle; shadows copied to actives on exit
//   SETTLE | SETTLE_CYC cycles of lock time, cfg_done pulses on exit
module adpll_cfg_ctrl
   import adpll_cfg_pkg::*;
#(
   parameter int HOLD_CYC   = 4,
   parameter int SETTLE_CYC = 16,
   parameter int CNT_W      = 5
) (
   input  logic             clk,
   input  logic             clr,
   adpll_cfg_ctrl_if.slave  cmd,
   output logic [3:0]       ndiv,
   output logic [4:0]       alpha,
   output logic [4:0]       beta,
   output logic [4:0]       dco_offset,
   output logic [4:0]       dco_thresh,
   output logic [4:0]       kdco,
   output logic             pll_rst,
   output logic             busy,
   output logic             cfg_done,
   output logic             cfg_err,
   output logic             cfg_applied
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cfg_done_q, cfg_done_d;
   logic               cfg_err_q, cfg_err_d;
   logic               cfg_applied_q, cfg_applied_d;
   logic               ready;
   logic               accept;
   logic [NUM_REGS-1:0] wr_en;
   logic               clear;
   logic               apply;
   logic [3:0]         shd_ndiv;

   assign ready  = (state_q == IDLE);
   assign accept = cmd.cmd_valid & ready;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cfg_done_d    = 1'b0;
      cfg_err_d     = cfg_err_q;
      cfg_applied_d = cfg_applied_q;
      wr_en         = '0;
      clear         = 1'b0;
      apply         = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (cmd.cmd_addr)
                  ADDR_COMMIT: begin
                     if (shd_ndiv < NDIV_MIN) begin
                        cfg_err_d = 1'b1;
                     end else begin
                        cfg_err_d = 1'b0;
                        state_d   = HOLD;
                        cnt_d     = '0;
                     end
                  end
                  ADDR_CLEAR: begin
                     clear     = 1'b1;
                     cfg_err_d = 1'b0;
                  end
                  default: begin
                     for (int i = 0; i < NUM_REGS; i++)
                        wr_en[i] = (cmd.cmd_addr == 3'(i));
                  end
               endcase
            end
         end
         HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYC-1)) begin
               state_d = APPLY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         APPLY: begin
            apply         = 1'b1;
            cfg_applied_d = 1'b1;
            state_d       = SETTLE;
            cnt_d         = '0;
         end
         SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC-1)) begin
               state_d    = IDLE;
               cnt_d      = '0;
               cfg_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cfg_done_q    <= 1'b0;
         cfg_err_q     <= 1'b0;
         cfg_applied_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cfg_done_q    <= cfg_done_d;
         cfg_err_q     <= cfg_err_d;
         cfg_applied_q <= cfg_applied_d;
      end
   end

   adpll_cfg_regbank u_regbank (
      .clk        (clk),
      .clr        (clr),
      .wr_en      (wr_en),
      .wr_data    (cmd.cmd_data),
      .clear      (clear),
      .apply      (apply),
      .shd_ndiv   (shd_ndiv),
      .ndiv       (ndiv),
      .alpha      (alpha),
      .beta       (beta),
      .dco_offset (dco_offset),
      .dco_thresh (dco_thresh),
      .kdco       (kdco)
   );

   // decoded from flops only so the core reset cannot glitch
   assign pll_rst       = (state_q == HOLD) | (state_q == APPLY) | ~cfg_applied_q;
   assign busy          = (state_q != IDLE);
   assign cmd.cmd_ready = ready;
   assign cfg_done      = cfg_done_q;
   assign cfg_err       = cfg_err_q;
   assign cfg_applied   = cfg_applied_q;

endmodule

// File: tb/tb_adpll_cfg_ctrl.sv
// Directed bench for adpll_cfg_ctrl with immediate-assertion checks.
module tb_adpll_cfg_ctrl;
   import adpll_cfg_pkg::*;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] ndiv;
   logic [4:0] alpha, beta, dco_offset, dco_thresh, kdco;
   logic       pll_rst, busy, cfg_done, cfg_err, cfg_applied;

   int n_cmp  = 0;
   int n_fail = 0;

   adpll_cfg_ctrl_if cmd_if ();

   adpll_cfg_ctrl #(.HOLD_CYC(4), .SETTLE_CYC(16), .CNT_W(5)) dut (
      .clk         (clk),
      .clr         (clr),
      .cmd         (cmd_if.slave),
      .ndiv        (ndiv),
      .alpha       (alpha),
      .beta        (beta),
      .dco_offset  (dco_offset),
      .dco_thresh  (dco_thresh),
      .kdco        (kdco),
      .pll_rst     (pll_rst),
      .busy        (busy),
      .cfg_done    (cfg_done),
      .cfg_err     (cfg_err),
      .cfg_applied (cfg_applied)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [28:0] outs();
      return {ndiv, alpha, beta, dco_offset, dco_thresh, kdco};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // returns #1 after the accept edge
   task automatic send(input logic [2:0] a, input logic [4:0] d, output int wait_cyc);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_addr  = a;
      cmd_if.cmd_data  = d;
      wait_cyc = 0;
      while (!cmd_if.cmd_ready && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("send_ready", 32'(cmd_if.cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
   endtask

   // observes k=0..24 cycles after a commit accept edge
   task automatic run_seq(output int rst_hi, output int fall_k, output int done_k,
                          output int done_cnt, output logic [28:0] pre, output logic [28:0] post);
      rst_hi = 0; fall_k = -1; done_k = -1; done_cnt = 0; pre = '0; post = '0;
      for (int k = 0; k <= 24; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (k <= 4 && pll_rst) rst_hi++;
         if (fall_k < 0 && !pll_rst) fall_k = k;
         if (cfg_done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (k == 4) pre = outs();
         if (k == 5) post = outs();
      end
   endtask

   initial begin
      int w, rh, fk, dk, dc, nb, nd;
      logic [28:0] pre, post;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_addr  = '0;
      cmd_if.cmd_data  = '0;

      // asynchronous reset before any clock edge
      #1 clr = 1'b1;
      #1;
      check("rst_outs", 32'(outs()), 32'd0);
      check("rst_pll_rst", 32'(pll_rst), 32'd1);
      check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_applied", 32'(cfg_applied), 32'd0);
      check("rst_err", 32'(cfg_err), 32'd0);
      repeat (2) @(negedge clk);
      clr = 1'b0;

      // program and commit
      send(ADDR_NDIV, 5'd8, w);
      send(ADDR_ALPHA, 5'd3, w);
      send(ADDR_BETA, 5'd1, w);
      send(ADDR_OFFSET, 5'd10, w);
      send(ADDR_THRESH, 5'd20, w);
      send(ADDR_KDCO, 5'd5, w);
      check("wr_no_apply", 32'(outs()), 32'd0);
      send(ADDR_COMMIT, 5'd0, w);
      check("c1_busy", 32'(busy), 32'd1);
      check("c1_ready", 32'(cmd_if.cmd_ready), 32'd0);
      run_seq(rh, fk, dk, dc, pre, post);
      check("c1_rst_hi", 32'(rh), 32'd5);
      check("c1_fall", 32'(fk), 32'd5);
      check("c1_done_k", 32'(dk), 32'd21);
      check("c1_done_cnt", 32'(dc), 32'd1);
      check("c1_pre", 32'(pre), 32'd0);
      check("c1_post", 32'(post), 32'({4'd8, 5'd3, 5'd1, 5'd10, 5'd20, 5'd5}));
      check("c1_applied", 32'(cfg_applied), 32'd1);
      check("c1_err", 32'(cfg_err), 32'd0);

      // invalid divider
      send(ADDR_CLEAR, 5'd0, w);
      send(ADDR_COMMIT, 5'd0, w);
      check("inv_err", 32'(cfg_err), 32'd1);
      check("inv_busy", 32'(busy), 32'd0);
      nb = 0; nd = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         if (busy) nb++;
         if (cfg_done) nd++;
      end
      check("inv_busy_cnt", 32'(nb), 32'd0);
      check("inv_done_cnt", 32'(nd), 32'd0);
      check("inv_outs", 32'(outs()), 32'({4'd8, 5'd3, 5'd1, 5'd10, 5'd20, 5'd5}));
      send(ADDR_NDIV, 5'd2, w);
      check("inv_err_sticky", 32'(cfg_err), 32'd1);
      send(ADDR_COMMIT, 5'd0, w);
      check("inv_err_clr", 32'(cfg_err), 32'd0);
      run_seq(rh, fk, dk, dc, pre, post);
      check("c2_done_k", 32'(dk), 32'd21);
      check("c2_pre", 32'(pre), 32'({4'd8, 5'd3, 5'd1, 5'd10, 5'd20, 5'd5}));
      check("c2_post", 32'(post), 32'({4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}));

      // backpressure during SETTLE
      send(ADDR_COMMIT, 5'd0, w);
      repeat (8) @(posedge clk);
      #1;
      check("bp_ready", 32'(cmd_if.cmd_ready), 32'd0);
      send(ADDR_ALPHA, 5'd7, w);
      check("bp_wait", 32'(w), 32'd13);
      check("bp_alpha_hold", 32'(alpha), 32'd0);
      check("bp_idle", 32'(busy), 32'd0);
      send(ADDR_COMMIT, 5'd0, w);
      run_seq(rh, fk, dk, dc, pre, post);
      check("c3_post", 32'(post), 32'({4'd2, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0}));
      check("c3_done_cnt", 32'(dc), 32'd1);

      // reconfigure kdco
      send(ADDR_KDCO, 5'd31, w);
      send(ADDR_COMMIT, 5'd0, w);
      run_seq(rh, fk, dk, dc, pre, post);
      check("c4_rst_hi", 32'(rh), 32'd5);
      check("c4_fall", 32'(fk), 32'd5);
      check("c4_pre", 32'(pre), 32'({4'd2, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0}));
      check("c4_post", 32'(post), 32'({4'd2, 5'd7, 5'd0, 5'd0, 5'd0, 5'd31}));

      // abort in HOLD
      send(ADDR_COMMIT, 5'd0, w);
      repeat (2) @(posedge clk);
      #3 clr = 1'b1;
      #1;
      check("ab_outs", 32'(outs()), 32'd0);
      check("ab_pll_rst", 32'(pll_rst), 32'd1);
      check("ab_ready", 32'(cmd_if.cmd_ready), 32'd1);
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_applied", 32'(cfg_applied), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      nb = 0; nd = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         if (busy) nb++;
         if (cfg_done) nd++;
      end
      check("ab_busy_cnt", 32'(nb), 32'd0);
      check("ab_done_cnt", 32'(nd), 32'd0);
      check("ab_outs_end", 32'(outs()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
